// File: rtl/lav_pkg.sv
// Shared types and constants for the lavatory arbiter.
// Slot states and requester class identifiers used by the arbiter and its slots.
package lav_pkg;

  typedef enum logic [1:0] {
    LAV_FREE     = 2'd0,
    LAV_RESERVED = 2'd1,
    LAV_OCCUPIED = 2'd2
  } lav_state_t;

  localparam logic CLS_W = 1'b0;
  localparam logic CLS_M = 1'b1;

endpackage

// File: rtl/lav_slot.sv
// One lavatory: FREE/RESERVED/OCCUPIED tracking driven by its door lock,
// with a reservation timer that releases an unclaimed reservation.
module lav_slot
  import lav_pkg::*;
#(
  parameter int RESERVE_CYCLES = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       grant,
  input  logic       lock,
  output lav_state_t state,
  output logic       eligible
);

  localparam int TW = (RESERVE_CYCLES > 1) ? $clog2(RESERVE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESERVE_CYCLES - 1);

  lav_state_t    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= LAV_FREE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // The lock closing always beats reservation expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      LAV_FREE: begin
        if (grant) begin
          state_nxt = LAV_RESERVED;
          timer_nxt = '0;
        end else if (lock) begin
          state_nxt = LAV_OCCUPIED;
        end
      end
      LAV_RESERVED: begin
        if (lock) begin
          state_nxt = LAV_OCCUPIED;
        end else if (timer == TIMER_LAST) begin
          state_nxt = LAV_FREE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      LAV_OCCUPIED: begin
        if (!lock) begin
          state_nxt = LAV_FREE;
        end
      end
      default: state_nxt = LAV_FREE;
    endcase
  end

  assign eligible = (state == LAV_FREE) && !lock;

endmodule

// File: rtl/lavatory_arbiter.sv
// Shares N_LAV lavatories between women (any slot) and men (MEN_MASK slots),
// granting at most one reservation per cycle with an alternating class priority.
module lavatory_arbiter
  import lav_pkg::*;
#(
  parameter int               N_LAV          = 3,
  parameter logic [N_LAV-1:0] MEN_MASK       = 3'b110,
  parameter int               RESERVE_CYCLES = 4,
  parameter int               IDX_W          = $clog2(N_LAV)
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 req_w,
  input  logic                 req_m,
  input  logic [N_LAV-1:0]     lock,
  output logic                 gnt_w,
  output logic                 gnt_m,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 avail_w,
  output logic                 avail_m,
  output logic [2*N_LAV-1:0]   lav_state
);

  lav_state_t       slot_state [N_LAV];
  logic [N_LAV-1:0] eligible;
  logic [N_LAV-1:0] elig_m;
  logic [N_LAV-1:0] elig_w_pref;
  logic [N_LAV-1:0] slot_grant;

  logic             ptr;
  logic             any_w;
  logic             any_m;
  logic             qual_w;
  logic             qual_m;
  logic             win_w;
  logic             win_m;
  logic             win_any;
  logic [IDX_W-1:0] idx_w;
  logic [IDX_W-1:0] idx_m;
  logic [IDX_W-1:0] idx_sel;

  for (genvar i = 0; i < N_LAV; i++) begin : g_slot
    lav_slot #(
      .RESERVE_CYCLES(RESERVE_CYCLES)
    ) u_slot (
      .clk_2   (clk_2),
      .reset   (reset),
      .grant   (slot_grant[i]),
      .lock    (lock[i]),
      .state   (slot_state[i]),
      .eligible(eligible[i])
    );
    assign lav_state[2*i +: 2] = slot_state[i];
  end

  assign elig_m      = eligible & MEN_MASK;
  assign elig_w_pref = eligible & ~MEN_MASK;
  assign any_w       = |eligible;
  assign any_m       = |elig_m;

  always_comb begin
    idx_m = '0;
    for (int i = N_LAV - 1; i >= 0; i--) begin
      if (elig_m[i]) idx_m = IDX_W'(i);
    end
  end

  // Women are steered to women-only slots first so men keep their capacity.
  always_comb begin
    idx_w = '0;
    if (|elig_w_pref) begin
      for (int i = N_LAV - 1; i >= 0; i--) begin
        if (elig_w_pref[i]) idx_w = IDX_W'(i);
      end
    end else begin
      for (int i = N_LAV - 1; i >= 0; i--) begin
        if (eligible[i]) idx_w = IDX_W'(i);
      end
    end
  end

  // A request seen while its own grant is still showing is the old request.
  always_comb begin
    qual_w  = req_w && !gnt_w && any_w;
    qual_m  = req_m && !gnt_m && any_m;
    win_w   = qual_w && (!qual_m || (ptr == CLS_W));
    win_m   = qual_m && !win_w;
    win_any = win_w || win_m;
    idx_sel = win_w ? idx_w : idx_m;
    slot_grant = '0;
    for (int i = 0; i < N_LAV; i++) begin
      slot_grant[i] = win_any && (idx_sel == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      gnt_w   <= 1'b0;
      gnt_m   <= 1'b0;
      gnt_idx <= '0;
      avail_w <= 1'b0;
      avail_m <= 1'b0;
      ptr     <= CLS_W;
    end else begin
      gnt_w   <= win_w;
      gnt_m   <= win_m;
      gnt_idx <= win_any ? idx_sel : '0;
      avail_w <= any_w;
      avail_m <= any_m;
      if (win_any) begin
        ptr <= (ptr == CLS_W) ? CLS_M : CLS_W;
      end
    end
  end

endmodule
